// File: rtl/fxp_mul_seq.sv
// Sequential signed fixed-point multiplier: radix-2 shift-add core followed by a
// leading-sign normalisation loop that renormalises the product to W bits with its own Q format.
module fxp_mul_seq #(
    parameter int W  = 16,
    parameter int QW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  DataA,
    input  logic [W-1:0]  DataB,
    input  logic [QW-1:0] QIa,
    input  logic [QW-1:0] QFa,
    input  logic [QW-1:0] QIb,
    input  logic [QW-1:0] QFb,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  Product,
    output logic [QW-1:0] QI_out,
    output logic [QW-1:0] QF_out,
    output logic          ovf
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
    localparam logic [QW:0]    ONE_Q    = (QW+1)'(1);
    localparam logic [QW:0]    Q_MAX    = (QW+1)'(W - 1);
    localparam logic [W-1:0]   ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_P    = {{(2*W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic           sign_q, sign_d;
    logic [QW:0]    q_q, q_d;
    logic [2*W-1:0] p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   product_q, product_d;
    logic [QW-1:0]  qi_q, qi_d;
    logic [QW-1:0]  qf_q, qf_d;
    logic           ovf_q, ovf_d;

    logic [W-1:0]   abs_a, abs_b;
    logic [QW:0]    q_sum;
    logic [2*W-1:0] p_sum;

    // The fractional widths are implied by QI + QF == W, so only the integer widths are needed.
    logic unused_qf;
    assign unused_qf = ^{QFa, QFb};

    // Magnitude of the most negative value stays correct as an unsigned W-bit number.
    assign abs_a = DataA[W-1] ? (~DataA + ONE_W) : DataA;
    assign abs_b = DataB[W-1] ? (~DataB + ONE_W) : DataB;
    assign q_sum = {1'b0, QIa} + {1'b0, QIb};
    assign p_sum = p_q + (mplier_q[0] ? mcand_q : {(2*W){1'b0}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            sign_q    <= 1'b0;
            q_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            qi_q      <= QW'(1);
            qf_q      <= QW'(W - 1);
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            sign_q    <= sign_d;
            q_q       <= q_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            qi_q      <= qi_d;
            qf_q      <= qf_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        sign_d    = sign_q;
        q_d       = q_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        qi_d      = qi_q;
        qf_d      = qf_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{W{1'b0}}, abs_a};
                    mplier_d = abs_b;
                    sign_d   = DataA[W-1] ^ DataB[W-1];
                    q_d      = q_sum;
                    p_d      = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                p_d      = p_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    p_d     = sign_q ? (~p_sum + ONE_P) : p_sum;
                    state_d = NORM;
                end
            end
            NORM: begin
                if ((p_q[2*W-1] == p_q[2*W-2]) && (q_q > ONE_Q)) begin
                    p_d = p_q << 1;
                    q_d = q_q - ONE_Q;
                end else begin
                    state_d = DONE;
                    if (q_q <= Q_MAX) begin
                        product_d = p_q[2*W-1:W];
                        qi_d      = q_q[QW-1:0];
                        qf_d      = QW'(W) - q_q[QW-1:0];
                        ovf_d     = 1'b0;
                    end else begin
                        product_d = sign_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                        qi_d      = QW'(W - 1);
                        qf_d      = QW'(1);
                        ovf_d     = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Product   = product_q;
    assign QI_out    = qi_q;
    assign QF_out    = qf_q;
    assign ovf       = ovf_q;

endmodule
